// File: rtl/vsrc_pkg.sv
// Shared types and helpers for the framebuffer scan-out reader.
package vsrc_pkg;

    // Request-side FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } vsrc_state_e;

    // DDR bursts must not cross this byte boundary.
    localparam int unsigned PAGE_BYTES = 4096;
    localparam int unsigned PAGE_SHIFT = 12;
    localparam int unsigned PAGE_WORDS = PAGE_BYTES / 4;

    // Burst beat count needs to represent 1..16.
    localparam int unsigned BEATS_W = 5;

    // Beats for the next burst: the smallest of the words left in the line,
    // the burst cap, and the words left before the next page boundary.
    function automatic logic [BEATS_W-1:0] burst_beats(
        input logic [31:0]        words_left,
        input logic [9:0]         page_word_off,
        input logic [BEATS_W-1:0] max_burst
    );
        logic [31:0]        to_page;
        logic [BEATS_W-1:0] beats;
        to_page = PAGE_WORDS - {22'd0, page_word_off};
        beats   = max_burst;
        if (words_left < 32'(beats)) begin
            beats = words_left[BEATS_W-1:0];
        end
        if (to_page < 32'(beats)) begin
            beats = to_page[BEATS_W-1:0];
        end
        return beats;
    endfunction

endpackage

// File: rtl/vsrc_fifo.sv
// Synchronous single-clock FIFO with occupancy count and combinational read port.
module vsrc_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 64
) (
    input  logic                     m_axis_vid_aclk,
    input  logic                     areset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full;

    // Storage write.
    // NOTE: the storage array has no reset; only pointers and count do, so an
    // empty FIFO never exposes stale words and the array maps onto RAM cells.
    always_ff @(posedge m_axis_vid_aclk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge m_axis_vid_aclk) begin
        if (areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end

    assign rd_data = mem[rd_ptr_q];
    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;

    // The credit scheme upstream makes both of these unreachable.
    a_no_overflow:  assert property (@(posedge m_axis_vid_aclk) disable iff (areset) !(wr_en && full));
    a_no_underflow: assert property (@(posedge m_axis_vid_aclk) disable iff (areset) !(rd_en && empty));

endmodule

// File: rtl/video_stream_source.sv
// Framebuffer scan-out reader: issues page-safe DDR bursts under a credit
// limit, buffers the returned words and emits them as an AXI4-Stream video
// stream with SOF on tuser and end-of-line on tlast.
module video_stream_source
    import vsrc_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned MAX_BURST  = 16,
    parameter int unsigned FIFO_DEPTH = 64,
    parameter int unsigned DIM_W      = 12
) (
    input  logic              m_axis_vid_aclk,
    input  logic              areset,
    input  logic              enable,
    input  logic [ADDR_W-1:0] fb_base,
    input  logic [DIM_W-1:0]  line_words,
    input  logic [ADDR_W-1:0] line_pitch,
    input  logic [DIM_W-1:0]  num_lines,
    output logic              rd_req_valid,
    input  logic              rd_req_ready,
    output logic [ADDR_W-1:0] rd_req_addr,
    output logic [3:0]        rd_req_len,
    input  logic              rd_data_valid,
    input  logic [31:0]       rd_data,
    output logic [31:0]       m_axis_vid_tdata,
    output logic              m_axis_vid_tvalid,
    input  logic              m_axis_vid_tready,
    output logic              m_axis_vid_tlast,
    output logic              m_axis_vid_tuser,
    output logic              frame_busy
);
    localparam int unsigned       CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    vsrc_state_e        state_q;
    vsrc_state_e        state_d;

    logic               cfg_ok;
    logic               latch_cfg;
    logic               req_fire;
    logic               line_end_burst;
    logic               last_burst;
    logic               credit_ok;
    logic               pop;
    logic               frame_done;
    logic [BEATS_W-1:0] beats;

    // Request-side shadow configuration and walk state.
    logic [ADDR_W-1:0]  pitch_q;
    logic [ADDR_W-1:0]  line_addr_q;
    logic [ADDR_W-1:0]  cur_addr_q;
    logic [DIM_W-1:0]   line_words_q;
    logic [DIM_W-1:0]   num_lines_q;
    logic [DIM_W-1:0]   words_left_q;
    logic [DIM_W-1:0]   lines_left_q;

    // Free FIFO slots not yet promised to an accepted request.
    logic [CNT_W-1:0]   credit_q;

    // One-stage register between the memory port and the FIFO.
    logic               beat_valid_q;
    logic [31:0]        beat_data_q;

    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;

    // Pop-side position within the frame.
    logic [DIM_W-1:0]   out_word_q;
    logic [DIM_W-1:0]   out_line_q;

    assign cfg_ok = enable && (line_words != '0) && (num_lines != '0);

    // Burst size depends only on walk state, so it holds while a request stalls.
    assign beats          = burst_beats(32'(words_left_q), cur_addr_q[PAGE_SHIFT-1:2], BEATS_W'(MAX_BURST));
    assign credit_ok      = (credit_q >= CNT_W'(beats));
    assign req_fire       = rd_req_valid && rd_req_ready;
    assign line_end_burst = (DIM_W'(beats) == words_left_q);
    assign last_burst     = line_end_burst && (lines_left_q == DIM_W'(1));

    assign rd_req_addr = cur_addr_q;
    assign rd_req_len  = 4'(beats - BEATS_W'(1));

    // State register.
    always_ff @(posedge m_axis_vid_aclk) begin
        if (areset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (cfg_ok)                  state_d = ST_REQ;
            ST_REQ:   if (req_fire && last_burst)  state_d = ST_DRAIN;
            ST_DRAIN: if (frame_done)              state_d = ST_IDLE;
            default:                               state_d = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        rd_req_valid = 1'b0;
        frame_busy   = 1'b0;
        latch_cfg    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                latch_cfg = cfg_ok;
            end
            ST_REQ: begin
                frame_busy   = 1'b1;
                rd_req_valid = credit_ok;
            end
            ST_DRAIN: begin
                frame_busy = 1'b1;
            end
            default: begin
                frame_busy = 1'b0;
            end
        endcase
    end

    // Config latch and address walk: line starts accumulate the pitch,
    // bursts within a line advance by their byte length.
    always_ff @(posedge m_axis_vid_aclk) begin
        if (areset) begin
            pitch_q      <= '0;
            line_addr_q  <= '0;
            cur_addr_q   <= '0;
            line_words_q <= '0;
            num_lines_q  <= '0;
            words_left_q <= '0;
            lines_left_q <= '0;
        end else if (latch_cfg) begin
            pitch_q      <= line_pitch & WORD_MASK;
            line_addr_q  <= fb_base & WORD_MASK;
            cur_addr_q   <= fb_base & WORD_MASK;
            line_words_q <= line_words;
            num_lines_q  <= num_lines;
            words_left_q <= line_words;
            lines_left_q <= num_lines;
        end else if (req_fire) begin
            if (line_end_burst) begin
                line_addr_q  <= line_addr_q + pitch_q;
                cur_addr_q   <= line_addr_q + pitch_q;
                words_left_q <= line_words_q;
                lines_left_q <= lines_left_q - DIM_W'(1);
            end else begin
                cur_addr_q   <= cur_addr_q + ADDR_W'({beats, 2'b00});
                words_left_q <= words_left_q - DIM_W'(beats);
            end
        end
    end

    // Credit: debit a whole burst on acceptance, return one per popped word.
    always_ff @(posedge m_axis_vid_aclk) begin
        if (areset) begin
            credit_q <= CNT_W'(FIFO_DEPTH);
        end else begin
            credit_q <= credit_q
                      - (req_fire ? CNT_W'(beats) : CNT_W'(0))
                      + (pop      ? CNT_W'(1)     : CNT_W'(0));
        end
    end

    // Register returning beats before they enter the FIFO.
    always_ff @(posedge m_axis_vid_aclk) begin
        if (areset) begin
            beat_valid_q <= 1'b0;
            beat_data_q  <= '0;
        end else begin
            beat_valid_q <= rd_data_valid;
            beat_data_q  <= rd_data;
        end
    end

    vsrc_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .m_axis_vid_aclk (m_axis_vid_aclk),
        .areset          (areset),
        .wr_en           (beat_valid_q),
        .wr_data         (beat_data_q),
        .rd_en           (pop),
        .rd_data         (m_axis_vid_tdata),
        .empty           (fifo_empty),
        .count           (fifo_count)
    );

    assign m_axis_vid_tvalid = !fifo_empty;
    assign pop               = m_axis_vid_tvalid && m_axis_vid_tready;
    assign m_axis_vid_tlast  = m_axis_vid_tvalid && (out_word_q == line_words_q - DIM_W'(1));
    assign m_axis_vid_tuser  = m_axis_vid_tvalid && (out_word_q == '0) && (out_line_q == '0);
    assign frame_done        = pop && m_axis_vid_tlast && (out_line_q == num_lines_q - DIM_W'(1));

    // Pop-side word/line counters; they move only on a stream handshake.
    always_ff @(posedge m_axis_vid_aclk) begin
        if (areset) begin
            out_word_q <= '0;
            out_line_q <= '0;
        end else if (latch_cfg) begin
            out_word_q <= '0;
            out_line_q <= '0;
        end else if (pop) begin
            if (m_axis_vid_tlast) begin
                out_word_q <= '0;
                out_line_q <= frame_done ? '0 : out_line_q + DIM_W'(1);
            end else begin
                out_word_q <= out_word_q + DIM_W'(1);
            end
        end
    end

    // Credits plus everything buffered can never exceed the FIFO size.
    a_credit_bound: assert property (@(posedge m_axis_vid_aclk) disable iff (areset)
        (32'(credit_q) + 32'(fifo_count) + 32'(beat_valid_q) <= FIFO_DEPTH));

endmodule

// File: tb/tb_video_stream_source.sv
// Directed bench for video_stream_source with a simple in-order DDR model.
module tb_video_stream_source;

    logic        clk = 1'b0;
    logic        areset;
    logic        enable;
    logic [31:0] fb_base;
    logic [11:0] line_words;
    logic [31:0] line_pitch;
    logic [11:0] num_lines;
    logic        rd_req_valid;
    logic        rd_req_ready;
    logic [31:0] rd_req_addr;
    logic [3:0]  rd_req_len;
    logic        rd_data_valid;
    logic [31:0] rd_data;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        tuser;
    logic        frame_busy;

    always #5 clk = ~clk;

    video_stream_source dut (
        .m_axis_vid_aclk   (clk),
        .areset            (areset),
        .enable            (enable),
        .fb_base           (fb_base),
        .line_words        (line_words),
        .line_pitch        (line_pitch),
        .num_lines         (num_lines),
        .rd_req_valid      (rd_req_valid),
        .rd_req_ready      (rd_req_ready),
        .rd_req_addr       (rd_req_addr),
        .rd_req_len        (rd_req_len),
        .rd_data_valid     (rd_data_valid),
        .rd_data           (rd_data),
        .m_axis_vid_tdata  (tdata),
        .m_axis_vid_tvalid (tvalid),
        .m_axis_vid_tready (tready),
        .m_axis_vid_tlast  (tlast),
        .m_axis_vid_tuser  (tuser),
        .frame_busy        (frame_busy)
    );

    int unsigned tests_run    = 0;
    int unsigned tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory model: each accepted beat returns data equal to its byte address.
    typedef struct {
        int unsigned due;
        logic [31:0] data;
    } beat_t;

    beat_t       pending[$];
    logic [35:0] req_q[$];
    logic [33:0] out_q[$];
    logic [35:0] exp_req[$];

    int unsigned cyc         = 0;
    int unsigned resp_delay  = 2;
    int          outstanding = 0;
    int          max_out     = 0;
    int unsigned stab_err    = 0;
    int          tready_mode = 1;   // 0 low, 1 high, 2 pattern
    int          rready_mode = 1;   // 1 always ready, 0 pattern

    always @(posedge clk) cyc <= cyc + 1;

    // Drive ready signals and response beats just after each rising edge.
    always @(posedge clk) begin
        beat_t b;
        #1;
        case (tready_mode)
            0:       tready = 1'b0;
            1:       tready = 1'b1;
            default: tready = (cyc % 3) != 0;
        endcase
        rd_req_ready = (rready_mode != 0) ? 1'b1 : ((cyc % 4) != 1);
        if (pending.size() > 0 && pending[0].due <= cyc) begin
            b             = pending.pop_front();
            rd_data_valid = 1'b1;
            rd_data       = b.data;
        end else begin
            rd_data_valid = 1'b0;
        end
    end

    // Observe handshakes on the falling edge and track stall stability.
    logic        prev_rstall = 1'b0;
    logic        prev_sstall = 1'b0;
    logic [35:0] prev_req;
    logic [33:0] prev_out;

    always @(negedge clk) begin
        if (areset) begin
            prev_rstall = 1'b0;
            prev_sstall = 1'b0;
        end else begin
            if (prev_rstall && !(rd_req_valid && {rd_req_addr, rd_req_len} == prev_req)) stab_err++;
            if (prev_sstall && !(tvalid && {tuser, tlast, tdata} == prev_out)) stab_err++;
            if (rd_req_valid && rd_req_ready) begin
                req_q.push_back({rd_req_addr, rd_req_len});
                for (int b = 0; b <= int'(rd_req_len); b++) begin
                    pending.push_back('{due: cyc + resp_delay + b, data: rd_req_addr + 32'(4 * b)});
                end
                outstanding += int'(rd_req_len) + 1;
            end
            if (tvalid && tready) begin
                out_q.push_back({tuser, tlast, tdata});
                outstanding--;
            end
            if (outstanding > max_out) max_out = outstanding;
            prev_rstall = rd_req_valid && !rd_req_ready;
            prev_req    = {rd_req_addr, rd_req_len};
            prev_sstall = tvalid && !tready;
            prev_out    = {tuser, tlast, tdata};
        end
    end

    task automatic clear_logs();
        req_q.delete();
        out_q.delete();
        exp_req.delete();
        max_out  = 0;
        stab_err = 0;
    endtask

    task automatic start_frame(input string tag, input logic [31:0] base, input logic [31:0] pitch,
                               input logic [11:0] lw, input logic [11:0] nl, input bit keep_enable);
        bit seen = 1'b0;
        @(posedge clk); #1;
        fb_base    = base;
        line_pitch = pitch;
        line_words = lw;
        num_lines  = nl;
        enable     = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (frame_busy) seen = 1'b1;
        end
        check({tag, " latch"}, 64'(seen), 64'd1);
        // Scramble the config ports: the running frame must ignore them.
        @(posedge clk); #1;
        if (!keep_enable) enable = 1'b0;
        fb_base    = 32'hDEAD_BEE0;
        line_pitch = 32'h0000_0040;
        line_words = 12'd7;
        num_lines  = 12'd9;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (!frame_busy) done = 1'b1;
        end
        check({tag, " frame_done"}, 64'(done), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic verify_frame(input string tag, input logic [31:0] base, input logic [31:0] pitch,
                                input int lw, input int nl);
        int idx;
        check({tag, " req_count"}, 64'(req_q.size()), 64'(exp_req.size()));
        for (int i = 0; i < exp_req.size() && i < req_q.size(); i++) begin
            check($sformatf("%s req%0d", tag, i), 64'(req_q[i]), 64'(exp_req[i]));
        end
        check({tag, " word_count"}, 64'(out_q.size()), 64'(lw * nl));
        for (int l = 0; l < nl; l++) begin
            for (int w = 0; w < lw; w++) begin
                logic [33:0] exp_w;
                idx   = l * lw + w;
                exp_w = {(l == 0 && w == 0), (w == lw - 1), base + pitch * 32'(l) + 32'(4 * w)};
                if (idx < out_q.size()) begin
                    check($sformatf("%s word%0d", tag, idx), 64'(out_q[idx]), 64'(exp_w));
                end
            end
        end
        check({tag, " stable"}, 64'(stab_err), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit any_busy;
        bit got;
        bit prev_pop_last;

        areset        = 1'b1;
        enable        = 1'b0;
        fb_base       = '0;
        line_words    = '0;
        line_pitch    = '0;
        num_lines     = '0;
        tready        = 1'b0;
        rd_req_ready  = 1'b0;
        rd_data_valid = 1'b0;
        rd_data       = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst rd_req_valid", 64'(rd_req_valid), 64'd0);
        check("rst tvalid",       64'(tvalid),       64'd0);
        check("rst tlast",        64'(tlast),        64'd0);
        check("rst tuser",        64'(tuser),        64'd0);
        check("rst frame_busy",   64'(frame_busy),   64'd0);
        @(posedge clk); #1;
        areset = 1'b0;

        // line_words = 0 keeps the block idle
        clear_logs();
        @(posedge clk); #1;
        line_words = 12'd0;
        num_lines  = 12'd2;
        enable     = 1'b1;
        any_busy   = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (frame_busy) any_busy = 1'b1;
        end
        check("zero_lw busy", 64'(any_busy), 64'd0);
        check("zero_lw reqs", 64'(req_q.size()), 64'd0);
        @(posedge clk); #1;
        enable = 1'b0;

        // Basic 4x2 frame
        clear_logs();
        exp_req.push_back({32'h0000_1000, 4'd3});
        exp_req.push_back({32'h0000_1100, 4'd3});
        start_frame("t1", 32'h0000_1000, 32'h0000_0100, 12'd4, 12'd2, 1'b0);
        wait_idle("t1", 300);
        verify_frame("t1", 32'h0000_1000, 32'h0000_0100, 4, 2);

        // 40-word lines split into 16/16/8, with backpressure on both ports
        clear_logs();
        tready_mode = 2;
        rready_mode = 0;
        exp_req.push_back({32'h0000_2000, 4'd15});
        exp_req.push_back({32'h0000_2040, 4'd15});
        exp_req.push_back({32'h0000_2080, 4'd7});
        exp_req.push_back({32'h0000_2200, 4'd15});
        exp_req.push_back({32'h0000_2240, 4'd15});
        exp_req.push_back({32'h0000_2280, 4'd7});
        start_frame("t2", 32'h0000_2000, 32'h0000_0200, 12'd40, 12'd2, 1'b0);
        wait_idle("t2", 1000);
        verify_frame("t2", 32'h0000_2000, 32'h0000_0200, 40, 2);
        tready_mode = 1;
        rready_mode = 1;

        // 4 KiB boundary split
        clear_logs();
        exp_req.push_back({32'h0000_0FF8, 4'd1});
        exp_req.push_back({32'h0000_1000, 4'd5});
        start_frame("t3", 32'h0000_0FF8, 32'h0000_0100, 12'd8, 12'd1, 1'b0);
        wait_idle("t3", 300);
        verify_frame("t3", 32'h0000_0FF8, 32'h0000_0100, 8, 1);

        // Credit limit under a 200-cycle stall
        clear_logs();
        tready_mode = 0;
        for (int k = 0; k < 13; k++) begin
            exp_req.push_back({32'h0000_4000 + 32'(64 * k), (k < 12) ? 4'd15 : 4'd7});
        end
        start_frame("t4", 32'h0000_4000, 32'h0000_0400, 12'd200, 12'd1, 1'b0);
        repeat (200) @(negedge clk);
        check("t4 stalled reqs",   64'(req_q.size()), 64'd4);
        check("t4 stalled words",  64'(out_q.size()), 64'd0);
        check("t4 credited beats", 64'(max_out),      64'd64);
        tready_mode = 1;
        wait_idle("t4", 2000);
        check("t4 max credited", 64'(max_out), 64'd64);
        verify_frame("t4", 32'h0000_4000, 32'h0000_0400, 200, 1);

        // Reset with a burst outstanding, then a fresh frame
        clear_logs();
        resp_delay = 40;
        start_frame("t5", 32'h0000_5000, 32'h0000_0100, 12'd5, 12'd1, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (req_q.size() == 1) got = 1'b1;
        end
        check("t5 burst issued", 64'(got), 64'd1);
        repeat (3) @(negedge clk);
        check("t5 outstanding", 64'(outstanding), 64'd5);
        @(posedge clk); #1;
        areset = 1'b1;
        pending.delete();
        @(posedge clk);
        @(negedge clk);
        check("t5 rd_req_valid", 64'(rd_req_valid), 64'd0);
        check("t5 tvalid",       64'(tvalid),       64'd0);
        check("t5 tlast",        64'(tlast),        64'd0);
        check("t5 tuser",        64'(tuser),        64'd0);
        check("t5 frame_busy",   64'(frame_busy),   64'd0);
        @(posedge clk); #1;
        areset      = 1'b0;
        resp_delay  = 2;
        outstanding = 0;
        pending.delete();
        clear_logs();
        exp_req.push_back({32'h0000_6000, 4'd3});
        start_frame("t5b", 32'h0000_6000, 32'h0000_0100, 12'd4, 12'd1, 1'b0);
        wait_idle("t5b", 300);
        verify_frame("t5b", 32'h0000_6000, 32'h0000_0100, 4, 1);

        // enable dropped during line 1 of 3
        clear_logs();
        exp_req.push_back({32'h0000_7000, 4'd3});
        exp_req.push_back({32'h0000_7080, 4'd3});
        exp_req.push_back({32'h0000_7100, 4'd3});
        start_frame("t6", 32'h0000_7000, 32'h0000_0080, 12'd4, 12'd3, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (out_q.size() >= 4) got = 1'b1;
        end
        check("t6 line1 reached", 64'(got), 64'd1);
        @(posedge clk); #1;
        enable        = 1'b0;
        got           = 1'b0;
        prev_pop_last = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (!frame_busy) begin
                got = 1'b1;
                check("t6 busy falls after tlast", 64'(prev_pop_last), 64'd1);
            end
            prev_pop_last = tvalid && tready && tlast;
        end
        check("t6 frame_done", 64'(got), 64'd1);
        repeat (30) @(negedge clk);
        check("t6 no new reqs", 64'(req_q.size()), 64'd3);
        check("t6 stays idle",  64'(frame_busy),   64'd0);
        verify_frame("t6", 32'h0000_7000, 32'h0000_0080, 4, 3);

        // Single-word lines
        clear_logs();
        tready_mode = 2;
        exp_req.push_back({32'h0000_8000, 4'd0});
        exp_req.push_back({32'h0000_8010, 4'd0});
        exp_req.push_back({32'h0000_8020, 4'd0});
        start_frame("t7", 32'h0000_8000, 32'h0000_0010, 12'd1, 12'd3, 1'b0);
        wait_idle("t7", 300);
        verify_frame("t7", 32'h0000_8000, 32'h0000_0010, 1, 3);
        tready_mode = 1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
